// File: rtl/nest_checker_pkg.sv
// Shared constants for the nested begin/end, case/endcase checker.
// Keywords are indexed 0..3 as begin, end, case, endcase.
package nest_checker_pkg;

  localparam logic [3:0] LEN_BEGIN   = 4'd5;
  localparam logic [3:0] LEN_END     = 4'd3;
  localparam logic [3:0] LEN_CASE    = 4'd4;
  localparam logic [3:0] LEN_ENDCASE = 4'd7;
  localparam logic [3:0] IDX_MAX     = 4'd8;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_UNDERFLOW = 2'd1;
  localparam logic [1:0] ERR_MISMATCH  = 2'd2;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd3;

  localparam logic TYPE_B = 1'b0;
  localparam logic TYPE_C = 1'b1;

  typedef enum logic [2:0] {
    TOK_NONE    = 3'd0,
    TOK_OPEN_B  = 3'd1,
    TOK_OPEN_C  = 3'd2,
    TOK_CLOSE_B = 3'd3,
    TOK_CLOSE_C = 3'd4
  } tok_kind_e;

  function automatic logic [3:0] kw_len(input logic [1:0] kw);
    case (kw)
      2'd0:    kw_len = LEN_BEGIN;
      2'd1:    kw_len = LEN_END;
      2'd2:    kw_len = LEN_CASE;
      default: kw_len = LEN_ENDCASE;
    endcase
  endfunction

  // Keywords are stored left-aligned in 56 bits; character i sits at byte i from the MSB.
  function automatic logic [7:0] kw_char(input logic [1:0] kw, input logic [3:0] i);
    logic [55:0] s;
    logic [5:0]  base;
    case (kw)
      2'd0:    s = {"begin", 16'h0000};
      2'd1:    s = {"end", 32'h0000_0000};
      2'd2:    s = {"case", 24'h00_0000};
      default: s = "endcase";
    endcase
    base = 6'd55 - {i[2:0], 3'b000};
    if (i < 4'd7) begin
      kw_char = s[base -: 8];
    end else begin
      kw_char = 8'h00;
    end
  endfunction

endpackage

// File: rtl/nest_checker_token_matcher.sv
// Case-folding keyword recogniser; emits a combinational token pulse on each space.
module token_matcher
  import nest_checker_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       in_valid_i,
  input  logic [7:0] in_i,
  output logic       tok_valid_o,
  output tok_kind_e  tok_kind_o
);

  logic [3:0] idx_q, idx_d;
  logic [3:0] live_q, live_d;
  logic [7:0] ch_s;

  // Fold upper-case letters to lower case.
  always_comb begin
    if (in_i >= 8'h41 && in_i <= 8'h5a) begin
      ch_s = in_i | 8'h20;
    end else begin
      ch_s = in_i;
    end
  end

  // Token evaluation on delimiters, flag pruning and index advance otherwise.
  always_comb begin
    idx_d       = idx_q;
    live_d      = live_q;
    tok_valid_o = 1'b0;
    tok_kind_o  = TOK_NONE;
    if (in_valid_i) begin
      if (ch_s == 8'h20) begin
        tok_valid_o = 1'b1;
        if (live_q[0] && idx_q == LEN_BEGIN) begin
          tok_kind_o = TOK_OPEN_B;
        end else if (live_q[1] && idx_q == LEN_END) begin
          tok_kind_o = TOK_CLOSE_B;
        end else if (live_q[2] && idx_q == LEN_CASE) begin
          tok_kind_o = TOK_OPEN_C;
        end else if (live_q[3] && idx_q == LEN_ENDCASE) begin
          tok_kind_o = TOK_CLOSE_C;
        end else begin
          tok_kind_o = TOK_NONE;
        end
        idx_d  = 4'd0;
        live_d = 4'hf;
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (idx_q >= kw_len(2'(k)) || ch_s != kw_char(2'(k), idx_q)) begin
            live_d[k] = 1'b0;
          end else begin
            live_d[k] = live_q[k];
          end
        end
        idx_d = (idx_q == IDX_MAX) ? IDX_MAX : idx_q + 4'd1;
      end
    end else begin
      idx_d = idx_q;
    end
  end

  // Matcher state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      idx_q  <= 4'd0;
      live_q <= 4'hf;
    end else begin
      idx_q  <= idx_d;
      live_q <= live_d;
    end
  end

endmodule

// File: rtl/nest_checker.sv
// LIFO keyword-nesting checker: typed stack, first-error latch and result flag.
module nest_checker
  import nest_checker_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int DW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          in_valid_i,
  input  logic [7:0]    in_i,
  output logic          result_o,
  output logic [DW-1:0] depth_o,
  output logic [1:0]    err_code_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             tok_valid_s;
  tok_kind_e        tok_kind_s;
  logic [DEPTH-1:0] stack_q, stack_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic [1:0]       err_q, err_d;
  logic [DW-1:0]    dm1_s;
  logic [AW-1:0]    push_ptr_s, top_ptr_s;
  logic             want_s;

  token_matcher u_matcher (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .in_valid_i  (in_valid_i),
    .in_i        (in_i),
    .tok_valid_o (tok_valid_s),
    .tok_kind_o  (tok_kind_s)
  );

  assign dm1_s      = depth_q - DW'(1);
  assign push_ptr_s = depth_q[AW-1:0];
  assign top_ptr_s  = dm1_s[AW-1:0];
  assign want_s     = (tok_kind_s == TOK_CLOSE_C) ? TYPE_C : TYPE_B;

  // Push/pop with error detection; everything freezes once an error is latched.
  always_comb begin
    stack_d = stack_q;
    depth_d = depth_q;
    err_d   = err_q;
    if (tok_valid_s && err_q == ERR_NONE) begin
      case (tok_kind_s)
        TOK_OPEN_B, TOK_OPEN_C: begin
          if (depth_q == DW'(DEPTH)) begin
            err_d = ERR_OVERFLOW;
          end else begin
            stack_d[push_ptr_s] = (tok_kind_s == TOK_OPEN_C) ? TYPE_C : TYPE_B;
            depth_d             = depth_q + DW'(1);
          end
        end
        TOK_CLOSE_B, TOK_CLOSE_C: begin
          if (depth_q == {DW{1'b0}}) begin
            err_d = ERR_UNDERFLOW;
          end else if (stack_q[top_ptr_s] != want_s) begin
            err_d = ERR_MISMATCH;
          end else begin
            depth_d = dm1_s;
          end
        end
        default: begin
          depth_d = depth_q;
        end
      endcase
    end else begin
      depth_d = depth_q;
    end
  end

  // Stack, depth and error registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stack_q <= {DEPTH{1'b0}};
      depth_q <= {DW{1'b0}};
      err_q   <= ERR_NONE;
    end else begin
      stack_q <= stack_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  assign depth_o    = depth_q;
  assign err_code_o = err_q;
  assign result_o   = (depth_q == {DW{1'b0}}) && (err_q == ERR_NONE);

endmodule

// File: tb/tb_nest_checker.sv
// Bench for nest_checker: DEPTH=16 and DEPTH=2 instances share one stream,
// checked each cycle against a token-level queue model plus directed expectations.
module tb_nest_checker;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       in_valid_i;
  logic [7:0] in_i;
  logic       r16, r2;
  logic [4:0] d16;
  logic [1:0] d2;
  logic [1:0] e16, e2;

  int checks = 0;
  int errors = 0;

  int  cap[2] = '{16, 2};
  int  m_stk[2][$];
  int  m_err[2];
  byte tok[$];

  string rtoks[10] = '{"begin", "end", "case", "endcase", "BEGIN", "EndCase",
                       "x", "beginx", "endcasexyz", "cas"};

  always #5 clk = ~clk;

  nest_checker #(.DEPTH(16)) dut16 (
    .clk_i(clk), .reset_i(reset_i), .in_valid_i(in_valid_i), .in_i(in_i),
    .result_o(r16), .depth_o(d16), .err_code_o(e16)
  );

  nest_checker #(.DEPTH(2)) dut2 (
    .clk_i(clk), .reset_i(reset_i), .in_valid_i(in_valid_i), .in_i(in_i),
    .result_o(r2), .depth_o(d2), .err_code_o(e2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit tok_is(input string kw);
    if (tok.size() != kw.len()) return 1'b0;
    for (int i = 0; i < kw.len(); i++) begin
      if (tok[i] != kw[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void m_push(input int i, input int t);
    if (m_stk[i].size() == cap[i]) m_err[i] = 3;
    else m_stk[i].push_back(t);
  endfunction

  function automatic void m_pop(input int i, input int t);
    if (m_stk[i].size() == 0) m_err[i] = 1;
    else if (m_stk[i][$] != t) m_err[i] = 2;
    else void'(m_stk[i].pop_back());
  endfunction

  function automatic void model_step(input bit v, input byte c);
    byte f;
    if (!v) return;
    if (c == 8'h20) begin
      for (int i = 0; i < 2; i++) begin
        if (m_err[i] == 0) begin
          if (tok_is("begin")) m_push(i, 0);
          else if (tok_is("case")) m_push(i, 1);
          else if (tok_is("end")) m_pop(i, 0);
          else if (tok_is("endcase")) m_pop(i, 1);
        end
      end
      tok.delete();
    end else begin
      f = (c >= 8'h41 && c <= 8'h5a) ? c + 8'h20 : c;
      tok.push_back(f);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_stk[i].delete();
      m_err[i] = 0;
    end
    tok.delete();
  endfunction

  task automatic check_all();
    chk("d16_depth", 32'(d16), m_stk[0].size());
    chk("d16_err", 32'(e16), m_err[0]);
    chk("d16_result", 32'(r16), (m_stk[0].size() == 0 && m_err[0] == 0) ? 1 : 0);
    chk("d2_depth", 32'(d2), m_stk[1].size());
    chk("d2_err", 32'(e2), m_err[1]);
    chk("d2_result", 32'(r2), (m_stk[1].size() == 0 && m_err[1] == 0) ? 1 : 0);
  endtask

  task automatic cycle(input bit v, input byte c);
    in_valid_i = v;
    in_i       = c;
    @(posedge clk);
    model_step(v, c);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    reset_i    = 1'b1;
    in_valid_i = 1'b1;
    in_i       = 8'h20;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    reset_i    = 1'b0;
    in_valid_i = 1'b0;
    check_all();
  endtask

  task automatic send_str(input string s);
    for (int j = 0; j < s.len(); j++) cycle(1'b1, s[j]);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) cycle(1'b0, 8'($urandom_range(0, 255)));
  endtask

  task automatic expect16(input string tag, input int d, input int e);
    chk({tag, "_d16"}, 32'(d16), d);
    chk({tag, "_e16"}, 32'(e16), e);
    chk({tag, "_r16"}, 32'(r16), (d == 0 && e == 0) ? 1 : 0);
  endtask

  task automatic expect2(input string tag, input int d, input int e);
    chk({tag, "_d2"}, 32'(d2), d);
    chk({tag, "_e2"}, 32'(e2), e);
    chk({tag, "_r2"}, 32'(r2), (d == 0 && e == 0) ? 1 : 0);
  endtask

  initial begin
    string s;
    byte   c;
    reset_i    = 1'b1;
    in_valid_i = 1'b0;
    in_i       = 8'h00;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    reset_i = 1'b0;
    expect16("reset", 0, 0);
    expect2("reset", 0, 0);

    send_str("begin ");   expect16("nest_1", 1, 0);
    send_str("case ");    expect16("nest_2", 2, 0);
    send_str("endcase "); expect16("nest_3", 1, 0);
    send_str("end ");     expect16("nest_4", 0, 0);

    send_str("BeGiN ");   expect16("fold_1", 1, 0);
    send_str("End ");     expect16("fold_2", 0, 0);

    send_str("beginx end ");
    expect16("underflow", 0, 1);
    do_reset();

    send_str("begin endcase ");
    expect16("mismatch", 1, 2);
    send_str("end ");
    expect16("frozen", 1, 2);
    do_reset();

    send_str("case case begin ");
    expect2("overflow", 2, 3);
    expect16("no_overflow16", 3, 0);
    do_reset();
    expect2("after_reset", 0, 0);

    send_str("beg");
    idle(3);
    send_str("in  ");
    expect16("gap_push", 1, 0);
    send_str("end");
    expect16("no_delim", 1, 0);
    do_reset();
    expect16("midtoken_reset", 0, 0);
    send_str(" end ");
    expect16("partial_discarded", 0, 1);
    do_reset();

    for (int k = 0; k < 16; k++) send_str("begin ");
    expect16("full16", 16, 0);
    send_str("case ");
    expect16("overflow16", 16, 3);
    do_reset();

    for (int t = 0; t < 400; t++) begin
      s = rtoks[$urandom_range(0, 9)];
      for (int j = 0; j < s.len(); j++) begin
        c = s[j];
        if (c >= 8'h61 && c <= 8'h7a && $urandom_range(0, 3) == 0) c = c - 8'h20;
        if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 2));
        cycle(1'b1, c);
      end
      if ($urandom_range(0, 39) == 0) begin
        do_reset();
      end else begin
        for (int j = 0; j < $urandom_range(1, 2); j++) cycle(1'b1, 8'h20);
      end
      if ((m_err[0] != 0 || m_err[1] != 0) && $urandom_range(0, 2) == 0) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
